// File: rtl/aes_block_sequencer.sv
// AES HWPE multi-block job sequencer: drives source stream, engine and sink
// stream per block, tracking per-block byte addresses.
module aes_block_sequencer #(
  parameter int ADDR_W          = 32,
  parameter int CNT_W           = 16,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int BYTES_PER_WORD  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  nblocks_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic              mode_i,
  output logic              src_req_start_o,
  input  logic              src_ready_start_i,
  input  logic              src_done_i,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [ADDR_W-1:0] snk_addr_o,
  output logic [CNT_W-1:0]  src_len_o,
  output logic [CNT_W-1:0]  snk_len_o,
  output logic              snk_req_start_o,
  input  logic              snk_ready_start_i,
  input  logic              snk_done_i,
  output logic              eng_start_o,
  output logic              eng_clear_o,
  output logic              eng_mode_o,
  input  logic              eng_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  blk_idx_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SRC_REQ, SRC_WAIT,
    SNK_REQ, SNK_WAIT, NEXT, FINISH
  } state_e;

  localparam logic [ADDR_W-1:0] STRIDE =
    ADDR_W'(WORDS_PER_BLOCK * BYTES_PER_WORD);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  nblk_q, nblk_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] src_base_q, src_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic              mode_q, mode_d;
  logic              src_seen_q, src_seen_d;
  logic              eng_seen_q, eng_seen_d;
  logic              src_ok, eng_ok;
  logic [ADDR_W-1:0] off;

  always_comb begin
    state_d    = state_q;
    nblk_d     = nblk_q;
    idx_d      = idx_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    mode_d     = mode_q;
    src_seen_d = src_seen_q;
    eng_seen_d = eng_seen_q;
    // Flags include same-cycle arrivals so the later done is not lost
    src_ok     = src_seen_q | src_done_i;
    eng_ok     = eng_seen_q | eng_done_i;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = LOAD;
          nblk_d     = nblocks_i;
          src_base_d = src_base_i;
          dst_base_d = dst_base_i;
          mode_d     = mode_i;
          idx_d      = '0;
        end
      end
      LOAD: begin
        state_d = (nblk_q == '0) ? FINISH : SRC_REQ;
      end
      SRC_REQ: begin
        if (src_ready_start_i) state_d = SRC_WAIT;
      end
      SRC_WAIT: begin
        if (src_ok && eng_ok) begin
          state_d    = SNK_REQ;
          src_seen_d = 1'b0;
          eng_seen_d = 1'b0;
        end else begin
          src_seen_d = src_ok;
          eng_seen_d = eng_ok;
        end
      end
      SNK_REQ: begin
        if (snk_ready_start_i) state_d = SNK_WAIT;
      end
      SNK_WAIT: begin
        if (snk_done_i) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == nblk_q - CNT_W'(1)) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = SRC_REQ;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear) begin
      state_d    = IDLE;
      nblk_d     = '0;
      idx_d      = '0;
      src_base_d = '0;
      dst_base_d = '0;
      mode_d     = 1'b0;
      src_seen_d = 1'b0;
      eng_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      nblk_q     <= '0;
      idx_q      <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      mode_q     <= 1'b0;
      src_seen_q <= 1'b0;
      eng_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nblk_q     <= nblk_d;
      idx_q      <= idx_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      mode_q     <= mode_d;
      src_seen_q <= src_seen_d;
      eng_seen_q <= eng_seen_d;
    end
  end

  assign off             = ADDR_W'(idx_q) * STRIDE;
  assign src_addr_o      = src_base_q + off;
  assign snk_addr_o      = dst_base_q + off;
  assign src_len_o       = CNT_W'(WORDS_PER_BLOCK);
  assign snk_len_o       = CNT_W'(WORDS_PER_BLOCK);
  assign src_req_start_o = (state_q == SRC_REQ);
  assign snk_req_start_o = (state_q == SNK_REQ);
  assign eng_start_o     = (state_q == SRC_REQ) & src_ready_start_i & ~clear;
  assign eng_clear_o     = (state_q == IDLE);
  assign eng_mode_o      = mode_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == FINISH) & ~clear;
  assign blk_idx_o       = idx_q;

endmodule
